mem_stage_banked: RTL and testbench

Parametrised, banked data-memory stage for the ASIP datapath, replacing the fixed four-bank `mem_stage` in the mem-stage of the pipeline. It decodes a byte address into bank, word index and validity, and performs byte-masked writes and synchronous reads. It runs a valid/ready request handshake with a one-cycle response that can be held under a downstream stall, so the stage can sit between the ALU and the write-back stage of a stalling pipeline.

---
 rtl/mem_stage_pkg.sv | 37 +++
 rtl/mem_stage_banked_if.sv | 18 +
 rtl/mem_bank.sv | 24 ++
 rtl/mem_stage_banked.sv | 77 +++++++
 tb/tb_mem_stage_banked.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and address-decode helper for the banked memory stage.
// The decode function takes field widths as arguments so one copy serves any parameterisation.
package mem_stage_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int WB        = DEF_WIDTH / 8;

  function automatic int log2(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  localparam int WB_BITS = log2(WB);

  typedef struct packed {
    logic [31:0] bank;
    logic [31:0] word_idx;
    logic        misaligned;
    logic        out_of_range;
  } decode_t;

  // Anything outside the offset, word-index and bank fields (within width) is out of range.
  function automatic decode_t decode_addr(input logic [63:0] addr, input int width,
                                          input int off_bits, input int idx_bits,
                                          input int bank_lsb, input int bank_bits);
    decode_t     d;
    logic [63:0] wmask, used;
    wmask          = (64'd1 << width) - 64'd1;
    used           = ((64'd1 << (off_bits + idx_bits)) - 64'd1) |
                     (((64'd1 << bank_bits) - 64'd1) << bank_lsb);
    d.misaligned   = |(addr & ((64'd1 << off_bits) - 64'd1));
    d.word_idx     = 32'((addr >> off_bits) & ((64'd1 << idx_bits) - 64'd1));
    d.bank         = 32'((addr >> bank_lsb) & ((64'd1 << bank_bits) - 64'd1));
    d.out_of_range = |(addr & wmask & ~used);
    return d;
  endfunction

endpackage

// File: rtl/mem_stage_banked_if.sv
// Request/response bus of the memory stage: valid/ready request, stallable one-cycle response.
interface mem_stage_banked_if #(parameter int WIDTH = 32);
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [WIDTH-1:0]   address;
  logic [WIDTH-1:0]   write_data;
  logic [WIDTH/8-1:0] byte_en;
  logic               resp_valid;
  logic               resp_stall;
  logic [WIDTH-1:0]   read_data;
  logic               resp_err;

  modport master (output req_valid, req_write, address, write_data, byte_en, resp_stall,
                  input  req_ready, resp_valid, read_data, resp_err);
  modport slave  (input  req_valid, req_write, address, write_data, byte_en, resp_stall,
                  output req_ready, resp_valid, read_data, resp_err);
endinterface

// File: rtl/mem_bank.sv
// Single-port DEPTH x WIDTH bank: byte-masked write, synchronous read gated by read enable.
module mem_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     re,
  input  logic                     we,
  input  logic [WIDTH/8-1:0]       be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // rdata only moves on an enabled read, so a held response keeps its data.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WIDTH/8; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_stage_banked.sv
// Banked data-memory pipeline stage: address decode, per-bank memories and a stallable
// single-entry response register muxed by the registered bank index.
module mem_stage_banked
  import mem_stage_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int BANKS    = 4,
  parameter int DEPTH    = 1024,
  parameter int BANK_LSB = 16
) (
  input  logic               clk,
  input  logic               rst,
  mem_stage_banked_if.slave  bus
);
  localparam int LANES     = WIDTH / 8;
  localparam int OFF_W     = log2(LANES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int BANK_BITS = log2(BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

  if (WIDTH % 8 != 0) begin : g_chk_width
    $fatal(1, "mem_stage_banked: WIDTH must be a multiple of 8");
  end
  if (OFF_W + IDX_W > BANK_LSB) begin : g_chk_map
    $fatal(1, "mem_stage_banked: word index overlaps bank field");
  end

  decode_t                       d;
  logic                          err, hold, accept;
  logic [BANK_W-1:0]             bank_sel, sel_q;
  logic [BANKS-1:0]              bank_we, bank_re;
  logic [BANKS-1:0][WIDTH-1:0]   bank_rdata;
  logic                          resp_valid_q, resp_err_q, rd_q;
  logic                          unused_ok;

  assign d        = decode_addr(64'(bus.address), WIDTH, OFF_W, IDX_W, BANK_LSB, BANK_BITS);
  assign err      = d.misaligned | d.out_of_range;
  assign bank_sel = d.bank[BANK_W-1:0];
  assign unused_ok = ^{d.bank[31:BANK_W], d.word_idx[31:IDX_W]};

  assign hold          = resp_valid_q && bus.resp_stall;
  assign bus.req_ready = !hold;
  // Requests seen while in reset are dropped, writes included.
  assign accept        = bus.req_valid && !hold && !rst;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign bank_we[b] = accept && bus.req_write  && !err && (bank_sel == BANK_W'(b));
    assign bank_re[b] = accept && !bus.req_write && !err && (bank_sel == BANK_W'(b));
    mem_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .re    (bank_re[b]),
      .we    (bank_we[b]),
      .be    (bus.byte_en),
      .addr  (d.word_idx[IDX_W-1:0]),
      .wdata (bus.write_data),
      .rdata (bank_rdata[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rd_q         <= 1'b0;
      sel_q        <= '0;
    end else if (!hold) begin
      resp_valid_q <= accept;
      resp_err_q   <= accept && err;
      rd_q         <= accept && !bus.req_write && !err;
      if (accept) sel_q <= bank_sel;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.read_data  = rd_q ? bank_rdata[sel_q] : '0;
endmodule

// File: tb/tb_mem_stage_banked.sv
// Directed bench for mem_stage_banked: hand-computed expectations checked with immediate assertions.
module tb_mem_stage_banked;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_stage_banked_if #(.WIDTH(32)) ifc ();

  mem_stage_banked #(.WIDTH(32), .BANKS(4), .DEPTH(1024), .BANK_LSB(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    ifc.req_valid  = 1'b1;
    ifc.req_write  = w;
    ifc.address    = a;
    ifc.write_data = wd;
    ifc.byte_en    = be;
  endtask

  // One request, one edge; the response is visible right after that edge.
  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    drive(w, a, wd, be);
    cyc();
    ifc.req_valid = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [31:0] data, input logic e);
    chk({tag, "_valid"}, 32'(ifc.resp_valid), 32'd1);
    chk({tag, "_data"},  ifc.read_data, data);
    chk({tag, "_err"},   32'(ifc.resp_err), 32'(e));
  endtask

  initial begin
    ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.address = '0;
    ifc.write_data = '0; ifc.byte_en = '0; ifc.resp_stall = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_valid", 32'(ifc.resp_valid), 32'd0);
    chk("rst_data",  ifc.read_data, 32'd0);
    chk("rst_err",   32'(ifc.resp_err), 32'd0);
    chk("rst_ready", 32'(ifc.req_ready), 32'd1);

    // Bank isolation
    req(1'b1, 32'h0,     32'h10,    4'hF); chk_resp("w_b0", 32'h0, 1'b0);
    req(1'b1, 32'h10000, 32'h10024, 4'hF); chk_resp("w_b1", 32'h0, 1'b0);
    req(1'b1, 32'h20000, 32'h20024, 4'hF); chk_resp("w_b2", 32'h0, 1'b0);
    req(1'b1, 32'h30000, 32'h30012, 4'hF); chk_resp("w_b3", 32'h0, 1'b0);
    req(1'b0, 32'h0,     '0, 4'h0); chk_resp("r_b0", 32'h10,    1'b0);
    req(1'b0, 32'h10000, '0, 4'h0); chk_resp("r_b1", 32'h10024, 1'b0);
    req(1'b0, 32'h20000, '0, 4'h0); chk_resp("r_b2", 32'h20024, 1'b0);
    req(1'b0, 32'h30000, '0, 4'h0); chk_resp("r_b3", 32'h30012, 1'b0);

    // Byte-masked write
    req(1'b1, 32'h20004, 32'hAABBCCDD, 4'hF);
    req(1'b1, 32'h20004, 32'h11223344, 4'h5);
    req(1'b0, 32'h20004, '0, 4'h0); chk_resp("r_mask", 32'hAA22CC44, 1'b0);

    // All-zero byte enable is a no-op
    req(1'b1, 32'h20004, 32'h0, 4'h0); chk_resp("w_be0", 32'h0, 1'b0);
    req(1'b0, 32'h20004, '0, 4'h0); chk_resp("r_be0", 32'hAA22CC44, 1'b0);

    // Back-to-back write then read of same address
    drive(1'b1, 32'h8, 32'h12, 4'hF);
    chk("b2b_ready0", 32'(ifc.req_ready), 32'd1);
    cyc();
    chk("b2b_ready1", 32'(ifc.req_ready), 32'd1);
    drive(1'b0, 32'h8, '0, 4'h0);
    cyc();
    ifc.req_valid = 1'b0;
    chk_resp("b2b_read", 32'h12, 1'b0);
    chk("b2b_ready2", 32'(ifc.req_ready), 32'd1);
    cyc();
    chk("idle_valid", 32'(ifc.resp_valid), 32'd0);
    chk("idle_data",  ifc.read_data, 32'd0);

    // Stall while idle has no effect on ready
    ifc.resp_stall = 1'b1;
    #1 chk("idle_stall_ready", 32'(ifc.req_ready), 32'd1);
    ifc.resp_stall = 1'b0;

    // Held response under stall, queued read released without bubble
    req(1'b0, 32'h10000, '0, 4'h0);
    ifc.resp_stall = 1'b1;
    drive(1'b0, 32'h0, '0, 4'h0);
    #1 chk("stall_ready", 32'(ifc.req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_resp("stall_hold", 32'h10024, 1'b0);
      chk("stall_ready_h", 32'(ifc.req_ready), 32'd0);
    end
    ifc.resp_stall = 1'b0;
    #1 chk("release_ready", 32'(ifc.req_ready), 32'd1);
    cyc();
    ifc.req_valid = 1'b0;
    chk_resp("release_read", 32'h10, 1'b0);

    // Errors
    req(1'b0, 32'h40000, '0, 4'h0); chk_resp("err_above", 32'h0, 1'b1);
    req(1'b0, 32'h1000,  '0, 4'h0); chk_resp("err_gap",   32'h0, 1'b1);
    req(1'b0, 32'h2,     '0, 4'h0); chk_resp("err_mis",   32'h0, 1'b1);
    req(1'b1, 32'h40000, 32'h55, 4'hF); chk_resp("err_wr", 32'h0, 1'b1);
    req(1'b0, 32'h0,     '0, 4'h0); chk_resp("err_keep",  32'h10, 1'b0);

    // Reset drops an in-flight write
    req(1'b1, 32'h4, 32'h77, 4'hF);
    req(1'b0, 32'h4, '0, 4'h0); chk_resp("pre_rst", 32'h77, 1'b0);
    drive(1'b1, 32'h4, 32'h99, 4'hF);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ifc.req_valid = 1'b0;
    chk("mrst_valid", 32'(ifc.resp_valid), 32'd0);
    chk("mrst_data",  ifc.read_data, 32'd0);
    chk("mrst_err",   32'(ifc.resp_err), 32'd0);
    req(1'b0, 32'h4, '0, 4'h0); chk_resp("post_rst", 32'h77, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
